// File: rtl/pir_light_ctrl.sv
// PIR-driven LED sequencer: synchronise and debounce the sensor, blank it during
// warm-up, hold the LED after motion ends, then blank retriggers after LED-off.
module pir_light_ctrl #(
   parameter int WARMUP_CYC   = 120_000_000,
   parameter int DEBOUNCE_CYC = 120_000,
   parameter int HOLD_CYC     = 60_000_000,
   parameter int BLANK_CYC    = 24_000_000
) (
   input  logic       hwclk,
   input  logic       rst_n,
   input  logic       pir_in,
   input  logic       enable,
   output logic       led_out,
   output logic [1:0] state_o,
   output logic [7:0] event_cnt
);

   localparam int WARM_W  = $clog2(WARMUP_CYC + 1);
   localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
   localparam int BLANK_W = $clog2(BLANK_CYC + 1);

   typedef enum logic [1:0] {
      S_WARMUP = 2'b00,
      S_IDLE   = 2'b01,
      S_ON     = 2'b10,
      S_BLANK  = 2'b11
   } state_t;

   state_t              r_state, w_state_nxt;
   logic                r_sync1, r_pir_s, r_filt, r_filt_d, r_led;
   logic [DB_W-1:0]     r_db_cnt;
   logic [WARM_W-1:0]   r_warm_cnt, w_warm_nxt;
   logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
   logic [BLANK_W-1:0]  r_blank_cnt, w_blank_nxt;
   logic [7:0]          r_event_cnt, w_event_cnt_nxt;
   logic                w_event;

   // Synchroniser and debounce run in every state so filt is settled when WARMUP ends.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_pir_s  <= 1'b0;
         r_filt   <= 1'b0;
         r_filt_d <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_sync1  <= pir_in;
         r_pir_s  <= r_sync1;
         r_filt_d <= r_filt;
         if (r_pir_s == r_filt) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            r_filt   <= r_pir_s;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end
      end
   end

   assign w_event = r_filt & ~r_filt_d;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_warm_nxt      = r_warm_cnt;
      w_hold_nxt      = r_hold;
      w_blank_nxt     = '0;
      w_event_cnt_nxt = r_event_cnt;
      case (r_state)
         S_WARMUP: begin
            if (r_warm_cnt == WARM_W'(WARMUP_CYC - 1)) w_state_nxt = S_IDLE;
            else                                       w_warm_nxt  = r_warm_cnt + WARM_W'(1);
         end
         S_IDLE: begin
            if (w_event && enable) begin
               w_state_nxt = S_ON;
               w_hold_nxt  = HOLD_W'(HOLD_CYC);
               if (r_event_cnt != 8'hFF) w_event_cnt_nxt = r_event_cnt + 8'd1;
            end
         end
         S_ON: begin
            // enable has priority over a retrigger arriving in the same cycle
            if (!enable) begin
               w_state_nxt = S_BLANK;
            end else if (r_filt) begin
               w_hold_nxt = HOLD_W'(HOLD_CYC);
            end else if (r_hold <= HOLD_W'(1)) begin
               w_hold_nxt  = '0;
               w_state_nxt = S_BLANK;
            end else begin
               w_hold_nxt = r_hold - HOLD_W'(1);
            end
         end
         S_BLANK: begin
            if (r_blank_cnt == BLANK_W'(BLANK_CYC - 1)) w_state_nxt = S_IDLE;
            else                                        w_blank_nxt = r_blank_cnt + BLANK_W'(1);
         end
         default: w_state_nxt = S_WARMUP;
      endcase
   end

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_WARMUP;
         r_warm_cnt  <= '0;
         r_hold      <= '0;
         r_blank_cnt <= '0;
         r_event_cnt <= '0;
         r_led       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_warm_cnt  <= w_warm_nxt;
         r_hold      <= w_hold_nxt;
         r_blank_cnt <= w_blank_nxt;
         r_event_cnt <= w_event_cnt_nxt;
         r_led       <= (w_state_nxt == S_ON);
      end
   end

   assign led_out   = r_led;
   assign state_o   = r_state;
   assign event_cnt = r_event_cnt;

endmodule
